noc_output_arbiter: RTL and testbench
=====================================

# noc_output_arbiter

Output-side stage of the 2x2 mesh NoC router, directly downstream of the per-port input stages. It collects 14-bit flits from the four input ports, grants the output link to one input at a time by round-robin, and holds the grant until that packet's end-of-packet flit has been accepted. Granted flits pass through one output register to the link with a valid/ready handshake.

## Interface
- NUM_IN, 4: number of input ports; must be a power of two, 2..4.
- FLIT_W, 14: flit width; layout [13] reserved, [12:11] dst_addr, [10:9] pack_t, [8:1] payload, [0] eop.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- in_valid  input  NUM_IN  per-input flit valid.
- in_flit  input  NUM_IN*FLIT_W  flattened flits; input i occupies bits [i*FLIT_W +: FLIT_W].
- in_ready  output  NUM_IN  per-input accept, combinational.
- out_valid  output  1  output register holds a flit.
- out_flit  output  FLIT_W  output flit, registered.
- out_ready  input  1  link accepts the flit.
- grant_id  output  $clog2(NUM_IN)  currently or last granted input, registered.
- busy  output  1  1 while state is LOCKED.
- pkt_count  output  8  count of eop flits delivered on the output.

## Operation
- States: IDLE, LOCKED. Reset state is IDLE.
- IDLE: if any in_valid is 1, select the first set bit searching rr_ptr, rr_ptr+1, … modulo NUM_IN. Register it into grant_id and go to LOCKED. If no in_valid is set, stay in IDLE. No flit is accepted in IDLE; all in_ready are 0.
- LOCKED: slot_free = !out_valid || out_ready.
  - in_ready[grant_id] = slot_free. All other in_ready bits are 0.
- Accept: an accept occurs when in_valid[g] && in_ready[g]. On accept, load out_flit with in_flit[g] unmodified, including the reserved bit, and set out_valid to 1.
- Output handshake: when out_valid && out_ready and there is no accept in the same cycle, out_valid goes to 0.
- End of packet: on an accept with eop=1, go to IDLE and set rr_ptr = grant_id + 1, wrapping to 0 after NUM_IN-1.
- pkt_count increments by 1 on each output handshake where out_flit[0]=1. It wraps from 255 to 0.
- A granted input deasserting in_valid mid-packet does not release the grant. The arbiter waits in LOCKED until the packet's eop flit is accepted.
- The arbiter does not inspect dst_addr or pack_t. Route selection happens upstream.

## Timing
- Reset values (one clk edge with rst=0): state=IDLE, rr_ptr=0, grant_id=0, busy=0, out_valid=0, out_flit=0, pkt_count=0. in_ready is 0 while rst=0.
- Reset mid-packet: the lock and any flit in the output register are discarded. The upstream input must re-send the packet.
- Arbitration latency: in_valid rises in cycle 0 with state IDLE. Grant and busy=1 are visible in cycle 1, and the first accept can occur in cycle 1. That flit appears on out_valid/out_flit in cycle 2.
- Throughput: 1 flit/cycle within a packet while out_ready=1. An accept and an output handshake in the same cycle overwrite the register, and out_valid stays 1.
- Backpressure: out_ready=0 with out_valid=1 holds in_ready=0. out_flit stays stable until the handshake.
- Inter-packet gap: at least one IDLE cycle after each eop accept. A single-flit packet (eop on the first flit) returns to IDLE in the cycle after its accept.
- The output register may still hold the eop flit while the next arbitration proceeds. The next packet's first accept waits for slot_free.

## Test plan
- Reset: hold rst=0 for 2 cycles with all in_valid=1. Required: out_valid=0, in_ready=0000, pkt_count=0, busy=0.
- Single requester: input 2 sends a 3-flit packet with payloads 0x11, 0x22, 0x33 (eop on the last), with out_ready=1. Required: busy=1 and grant_id=2 in cycle 1; flits on out_flit in cycles 2–4 in order; pkt_count=1; rr_ptr=3.
- Round-robin fairness: all four inputs continuously send 1-flit packets from reset. Required: grant order 0, 1, 2, 3, 0, and pkt_count=5 after those five deliveries.
- Lock hold: input 1 is granted and drops in_valid for 3 cycles mid-packet while input 0 requests. Required: grant_id stays 1, in_ready[0]=0, and input 0 is granted only after input 1's eop flit.
- Backpressure: hold out_ready=0 for 4 cycles mid-packet. Required: out_flit stable, in_ready[g]=0, no flit lost or duplicated after out_ready returns to 1.
- Wrap and reset: deliver 256 eop flits and check pkt_count wraps to 0. Then assert rst mid-packet and check that all reset values return after one edge.

Source files
------------

// File: rtl/noc_output_arbiter_if.sv
// Handshake bundle between the four NoC input stages, the output arbiter and the output link.
// The arbiter connects through the master modport; the surrounding router (or bench) uses slave.
interface noc_output_arbiter_if #(
  parameter int NUM_IN = 4,
  parameter int FLIT_W = 14
);
  localparam int GW = $clog2(NUM_IN);

  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN*FLIT_W-1:0] in_flit;
  logic [NUM_IN-1:0]        in_ready;
  logic                     out_valid;
  logic [FLIT_W-1:0]        out_flit;
  logic                     out_ready;
  logic [GW-1:0]            grant_id;
  logic                     busy;
  logic [7:0]               pkt_count;

  modport master (
    input  in_valid, in_flit, out_ready,
    output in_ready, out_valid, out_flit, grant_id, busy, pkt_count
  );

  modport slave (
    output in_valid, in_flit, out_ready,
    input  in_ready, out_valid, out_flit, grant_id, busy, pkt_count
  );
endinterface

// File: rtl/noc_output_arbiter.sv
// Round-robin output arbiter: locks the link to one input until its eop flit is accepted,
// then forwards flits through a single output register with valid/ready handshake.
module noc_output_arbiter #(
  parameter int NUM_IN = 4,
  parameter int FLIT_W = 14
) (
  input logic                 clk,
  input logic                 rst,
  noc_output_arbiter_if.master bus
);
  localparam int GW = $clog2(NUM_IN);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic              out_valid_q, out_valid_d;
  logic [FLIT_W-1:0] out_flit_q, out_flit_d;
  logic [7:0]        pkt_count_q, pkt_count_d;

  logic [FLIT_W-1:0] flits [NUM_IN];
  logic [GW-1:0]     scan_idx;
  logic [GW-1:0]     sel_idx;
  logic              sel_found;
  logic              slot_free;
  logic              accept;
  logic              out_hs;
  logic [NUM_IN-1:0] in_ready;

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      flits[i] = bus.in_flit[i*FLIT_W +: FLIT_W];
    end
  end

  // Search starts at rr_ptr; NUM_IN is a power of two so GW-bit addition wraps for free.
  always_comb begin
    scan_idx  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      scan_idx = rr_ptr_q + GW'(k);
      if (!sel_found && bus.in_valid[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  assign slot_free = !out_valid_q || bus.out_ready;
  assign accept    = rst && (state_q == LOCKED) && slot_free && bus.in_valid[grant_q];
  assign out_hs    = out_valid_q && bus.out_ready;

  always_comb begin
    in_ready = '0;
    if (rst && (state_q == LOCKED)) begin
      in_ready[grant_q] = slot_free;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    out_valid_d = out_valid_q;
    out_flit_d  = out_flit_q;
    pkt_count_d = pkt_count_q;

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d = sel_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && flits[grant_q][0]) begin
          state_d  = IDLE;
          rr_ptr_d = grant_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A same-cycle accept refills the register, so out_valid only drops on a bare handshake.
    if (accept) begin
      out_flit_d  = flits[grant_q];
      out_valid_d = 1'b1;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end

    if (out_hs && out_flit_q[0]) begin
      pkt_count_d = pkt_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_flit  = out_flit_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state_q == LOCKED);
  assign bus.pkt_count = pkt_count_q;
endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed bench for noc_output_arbiter: reset, single packet, round-robin order, lock hold,
// backpressure, pkt_count wrap and mid-packet reset.
module tb_noc_output_arbiter;
  localparam int N = 4;
  localparam int W = 14;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] fl [N];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  noc_output_arbiter_if #(.NUM_IN(N), .FLIT_W(W)) bus ();

  assign bus.in_flit = {fl[3], fl[2], fl[1], fl[0]};

  noc_output_arbiter #(.NUM_IN(N), .FLIT_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [W-1:0] mk(input logic rsv, input logic [7:0] pl, input logic eop);
    return {rsv, 2'b01, 2'b10, pl, eop};
  endfunction

  // Leaves the bench on a falling edge with rst released and the arbiter IDLE.
  task automatic do_reset();
    rst = 1'b0;
    bus.in_valid = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) fl[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) fl[i] = mk(1'b0, 8'(i), 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 0000", bus.in_ready); end
    checks++; if (bus.pkt_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_pkt_count got %0d want 0", bus.pkt_count); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_grant got %0d want 0", bus.grant_id); end
    checks++; if (bus.out_flit !== 14'h0) begin errors++; $display("[TB] FAIL reset_out_flit got %h want 0", bus.out_flit); end
  endtask

  task automatic test_single();
    do_reset();
    fl[2] = mk(1'b0, 8'h11, 1'b0);
    bus.in_valid = 4'b0100;
    #1;
    checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("[TB] FAIL single_idle_ready got %b want 0000", bus.in_ready); end
    @(negedge clk); #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy got %b want 1", bus.busy); end
    checks++; if (bus.grant_id !== 2'd2) begin errors++; $display("[TB] FAIL single_grant got %0d want 2", bus.grant_id); end
    checks++; if (bus.in_ready !== 4'b0100) begin errors++; $display("[TB] FAIL single_ready got %b want 0100", bus.in_ready); end
    @(negedge clk);
    fl[2] = mk(1'b0, 8'h22, 1'b0);
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_flit !== mk(1'b0, 8'h11, 1'b0)) begin errors++; $display("[TB] FAIL single_flit0 got %b/%h want 1/%h", bus.out_valid, bus.out_flit, mk(1'b0, 8'h11, 1'b0)); end
    @(negedge clk);
    fl[2] = mk(1'b0, 8'h33, 1'b1);
    #1;
    checks++; if (bus.out_flit !== mk(1'b0, 8'h22, 1'b0)) begin errors++; $display("[TB] FAIL single_flit1 got %h want %h", bus.out_flit, mk(1'b0, 8'h22, 1'b0)); end
    @(negedge clk);
    bus.in_valid = 4'b0000;
    #1;
    checks++; if (bus.out_flit !== mk(1'b0, 8'h33, 1'b1)) begin errors++; $display("[TB] FAIL single_flit2 got %h want %h", bus.out_flit, mk(1'b0, 8'h33, 1'b1)); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL single_release got %b want 0", bus.busy); end
    @(negedge clk);
    for (int i = 0; i < N; i++) fl[i] = mk(1'b0, 8'(i), 1'b1);
    bus.in_valid = 4'b1111;
    #1;
    checks++; if (bus.pkt_count !== 8'd1) begin errors++; $display("[TB] FAIL single_pkt_count got %0d want 1", bus.pkt_count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drain got %b want 0", bus.out_valid); end
    @(negedge clk); #1;
    checks++; if (bus.grant_id !== 2'd3) begin errors++; $display("[TB] FAIL single_rr_next got %0d want 3", bus.grant_id); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) fl[i] = mk(1'b0, 8'hA0 + 8'(i), 1'b1);
    bus.in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      checks++; if (bus.busy !== 1'b1 || bus.grant_id !== 2'(k % 4)) begin errors++; $display("[TB] FAIL rr_grant%0d got %b/%0d want 1/%0d", k, bus.busy, bus.grant_id, k % 4); end
      @(negedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_flit !== mk(1'b0, 8'hA0 + 8'(k % 4), 1'b1)) begin errors++; $display("[TB] FAIL rr_flit%0d got %b/%h want 1/%h", k, bus.out_valid, bus.out_flit, mk(1'b0, 8'hA0 + 8'(k % 4), 1'b1)); end
    end
    @(negedge clk); #1;
    checks++; if (bus.pkt_count !== 8'd5) begin errors++; $display("[TB] FAIL rr_pkt_count got %0d want 5", bus.pkt_count); end
  endtask

  task automatic test_lock_hold();
    do_reset();
    fl[1] = mk(1'b0, 8'h41, 1'b0);
    fl[0] = mk(1'b0, 8'h50, 1'b1);
    bus.in_valid = 4'b0010;
    @(negedge clk); #1;
    checks++; if (bus.grant_id !== 2'd1 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL lock_grant got %0d/%b want 1/1", bus.grant_id, bus.busy); end
    @(negedge clk);
    bus.in_valid = 4'b0001;
    #1;
    checks++; if (bus.in_ready !== 4'b0010) begin errors++; $display("[TB] FAIL lock_ready got %b want 0010", bus.in_ready); end
    checks++; if (bus.out_flit !== mk(1'b0, 8'h41, 1'b0)) begin errors++; $display("[TB] FAIL lock_flit0 got %h want %h", bus.out_flit, mk(1'b0, 8'h41, 1'b0)); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++; if (bus.grant_id !== 2'd1 || bus.busy !== 1'b1 || bus.in_ready[0] !== 1'b0) begin errors++; $display("[TB] FAIL lock_hold%0d got %0d/%b/%b want 1/1/0", c, bus.grant_id, bus.busy, bus.in_ready[0]); end
    end
    @(negedge clk);
    fl[1] = mk(1'b0, 8'h42, 1'b1);
    bus.in_valid = 4'b0011;
    #1;
    checks++; if (bus.grant_id !== 2'd1) begin errors++; $display("[TB] FAIL lock_still got %0d want 1", bus.grant_id); end
    @(negedge clk);
    bus.in_valid = 4'b0001;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.out_flit !== mk(1'b0, 8'h42, 1'b1)) begin errors++; $display("[TB] FAIL lock_eop got %b/%h want 0/%h", bus.busy, bus.out_flit, mk(1'b0, 8'h42, 1'b1)); end
    @(negedge clk); #1;
    checks++; if (bus.grant_id !== 2'd0 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL lock_next got %0d/%b want 0/1", bus.grant_id, bus.busy); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] p [4];
    logic [W-1:0] got [$];
    int idx;
    do_reset();
    for (int i = 0; i < 4; i++) p[i] = mk(i == 1, 8'hC0 + 8'(i), i == 3);
    idx = 0;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) @(negedge clk);
      bus.out_ready = !(c >= 3 && c <= 6);
      bus.in_valid = (idx < 4) ? 4'b1000 : 4'b0000;
      fl[3] = p[(idx < 4) ? idx : 3];
      #1;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_flit);
      if (c >= 3 && c <= 6) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_flit !== p[1]) begin errors++; $display("[TB] FAIL bp_stable%0d got %b/%h want 1/%h", c, bus.out_valid, bus.out_flit, p[1]); end
        checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("[TB] FAIL bp_ready%0d got %b want 0000", c, bus.in_ready); end
      end
      if (bus.in_valid[3] && bus.in_ready[3]) idx++;
    end
    checks++; if (got.size() != 4) begin errors++; $display("[TB] FAIL bp_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== p[i]) begin errors++; $display("[TB] FAIL bp_order%0d got %h want %h", i, got[i], p[i]); end
    end
    checks++; if (bus.pkt_count !== 8'd1) begin errors++; $display("[TB] FAIL bp_pkt_count got %0d want 1", bus.pkt_count); end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    fl[0] = mk(1'b0, 8'hEE, 1'b1);
    bus.in_valid = 4'b0001;
    repeat (511) @(negedge clk);
    #1;
    checks++; if (bus.pkt_count !== 8'd255) begin errors++; $display("[TB] FAIL wrap_255 got %0d want 255", bus.pkt_count); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.pkt_count !== 8'd0) begin errors++; $display("[TB] FAIL wrap_0 got %0d want 0", bus.pkt_count); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL wrap_busy got %b want 1", bus.busy); end
    fl[0] = mk(1'b0, 8'h77, 1'b0);
    @(negedge clk); #1;
    checks++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_flit !== mk(1'b0, 8'h77, 1'b0)) begin errors++; $display("[TB] FAIL mid_pkt got %b/%b/%h want 1/1/%h", bus.busy, bus.out_valid, bus.out_flit, mk(1'b0, 8'h77, 1'b0)); end
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("[TB] FAIL rst_ready got %b want 0000", bus.in_ready); end
    @(negedge clk); #1;
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_flit !== 14'h0) begin errors++; $display("[TB] FAIL rst_state got %b/%b/%h want 0/0/0", bus.busy, bus.out_valid, bus.out_flit); end
    checks++; if (bus.pkt_count !== 8'd0 || bus.grant_id !== 2'd0) begin errors++; $display("[TB] FAIL rst_counters got %0d/%0d want 0/0", bus.pkt_count, bus.grant_id); end
    rst = 1'b1;
    for (int i = 0; i < N; i++) fl[i] = mk(1'b0, 8'(i), 1'b1);
    bus.in_valid = 4'b1111;
    @(negedge clk); #1;
    checks++; if (bus.grant_id !== 2'd0 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_rr_ptr got %0d/%b want 0/1", bus.grant_id, bus.busy); end
  endtask

  initial begin
    $display("[TB] noc_output_arbiter directed tests");
    test_reset();
    test_single();
    test_round_robin();
    test_lock_hold();
    test_backpressure();
    test_wrap_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
